// File: rtl/collision_detector.sv
// rtl/collision_detector.sv - ball vs scene-object overlap counting with per-class thresholded, cooled-down collision pulses
module collision_detector #(
  parameter int MIN_OVERLAP     = 4,
  parameter int CNT_W           = 8,
  parameter int COOLDOWN_FRAMES = 2
) (
  input  logic       clk,
  input  logic       resetN,
  input  logic       startOfFrame,
  input  logic       pause,
  input  logic       reset_level,
  input  logic       draw_smiley,
  input  logic       draw_borderTop,
  input  logic       draw_borderLeft,
  input  logic       draw_borderRight,
  input  logic       draw_flipper,
  input  logic       draw_obstacle,
  output logic       collisionSmileyBorderTop,
  output logic       collisionSmileyBorderLeft,
  output logic       collisionSmileyBorderRight,
  output logic       collisionSmileyFlipper,
  output logic       collisionSmileyObstacle,
  output logic       collisionAny,
  output logic [4:0] frameHitMask
);

  localparam int NC   = 5;
  localparam int CD_W = (COOLDOWN_FRAMES < 2) ? 1 : $clog2(COOLDOWN_FRAMES + 1);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] MIN_OV  = CNT_W'(MIN_OVERLAP);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CD_W-1:0]  COOL_LD = CD_W'(COOLDOWN_FRAMES);
  localparam logic [CD_W-1:0]  CD_ONE  = CD_W'(1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FIRED = 2'd1,
    S_COOL  = 2'd2
  } state_e;

  // Class order matches frameHitMask: {OBST, FLIP, RIGHT, LEFT, TOP}
  logic [NC-1:0] draw;
  logic [NC-1:0] hit;

  assign draw = {draw_obstacle, draw_flipper, draw_borderRight, draw_borderLeft, draw_borderTop};
  assign hit  = draw & {NC{draw_smiley}};

  logic [CNT_W-1:0] cnt_q   [NC];
  logic [CNT_W-1:0] cnt_d   [NC];
  state_e           state_q [NC];
  state_e           state_d [NC];
  logic [CD_W-1:0]  cool_q  [NC];
  logic [CD_W-1:0]  cool_d  [NC];
  logic [NC-1:0]    pulse_q;
  logic [NC-1:0]    pulse_d;
  logic [NC-1:0]    mask_q;
  logic [NC-1:0]    mask_d;

  always_comb begin
    mask_d  = mask_q;
    pulse_d = '0;
    for (int c = 0; c < NC; c++) begin
      cnt_d[c]   = cnt_q[c];
      state_d[c] = state_q[c];
      cool_d[c]  = cool_q[c];

      if (reset_level) begin
        cnt_d[c]   = '0;
        state_d[c] = S_IDLE;
        cool_d[c]  = '0;
        mask_d[c]  = 1'b0;
      end else if (!pause) begin
        if (startOfFrame) begin
          cnt_d[c]  = hit[c] ? CNT_ONE : '0;
          mask_d[c] = (state_q[c] == S_FIRED);
          case (state_q[c])
            S_FIRED: begin
              cool_d[c]  = COOL_LD;
              state_d[c] = (COOL_LD == '0) ? S_IDLE : S_COOL;
            end
            S_COOL: begin
              cool_d[c] = cool_q[c] - CD_ONE;
              if (cool_q[c] == CD_ONE) begin
                state_d[c] = S_IDLE;
              end
            end
            default: ;
          endcase
        end else if (hit[c] && (cnt_q[c] != CNT_MAX)) begin
          cnt_d[c] = cnt_q[c] + CNT_ONE;
        end

        // Fire only on the edge the count steps onto the threshold; a saturated
        // counter sitting at MIN_OVERLAP must not retrigger.
        if ((state_d[c] == S_IDLE) && (cool_d[c] == '0) && hit[c] &&
            (cnt_d[c] == MIN_OV) && (startOfFrame || (cnt_q[c] != MIN_OV))) begin
          pulse_d[c] = 1'b1;
          state_d[c] = S_FIRED;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge resetN) begin
    if (!resetN) begin
      for (int c = 0; c < NC; c++) begin
        cnt_q[c]   <= '0;
        state_q[c] <= S_IDLE;
        cool_q[c]  <= '0;
      end
      pulse_q <= '0;
      mask_q  <= '0;
    end else begin
      for (int c = 0; c < NC; c++) begin
        cnt_q[c]   <= cnt_d[c];
        state_q[c] <= state_d[c];
        cool_q[c]  <= cool_d[c];
      end
      pulse_q <= pulse_d;
      mask_q  <= mask_d;
    end
  end

  // A pulse registered as pause rises is masked here and lost; the class is already FIRED.
  logic [NC-1:0] pulse_out;
  assign pulse_out = pulse_q & {NC{~pause}};

  assign collisionSmileyBorderTop   = pulse_out[0];
  assign collisionSmileyBorderLeft  = pulse_out[1];
  assign collisionSmileyBorderRight = pulse_out[2];
  assign collisionSmileyFlipper     = pulse_out[3];
  assign collisionSmileyObstacle    = pulse_out[4];
  assign collisionAny               = |pulse_out;
  assign frameHitMask               = mask_q;

endmodule

// File: tb/tb_collision_detector.sv
// tb/tb_collision_detector.sv - directed self-checking bench for collision_detector
module tb_collision_detector;

  logic       clk = 1'b0;
  logic       resetN;
  logic       sof;
  logic       pause;
  logic       rl;
  logic       sm;
  logic [4:0] obj;

  logic       c_top, c_left, c_right, c_flip, c_obst, c_any;
  logic [4:0] mask;
  logic [4:0] pulses;

  assign pulses = {c_obst, c_flip, c_right, c_left, c_top};

  collision_detector #(
    .MIN_OVERLAP    (4),
    .CNT_W          (8),
    .COOLDOWN_FRAMES(2)
  ) dut (
    .clk                       (clk),
    .resetN                    (resetN),
    .startOfFrame              (sof),
    .pause                     (pause),
    .reset_level               (rl),
    .draw_smiley               (sm),
    .draw_borderTop            (obj[0]),
    .draw_borderLeft           (obj[1]),
    .draw_borderRight          (obj[2]),
    .draw_flipper              (obj[3]),
    .draw_obstacle             (obj[4]),
    .collisionSmileyBorderTop  (c_top),
    .collisionSmileyBorderLeft (c_left),
    .collisionSmileyBorderRight(c_right),
    .collisionSmileyFlipper    (c_flip),
    .collisionSmileyObstacle   (c_obst),
    .collisionAny              (c_any),
    .frameHitMask              (mask)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  // Drive one pixel cycle, then return 1 time unit after the edge that consumed it.
  task automatic tick(input logic s, input logic [4:0] o, input logic f);
    sm  = s;
    obj = o;
    sof = f;
    @(posedge clk);
    #1;
    sm  = 1'b0;
    obj = '0;
    sof = 1'b0;
  endtask

  task automatic do_reset();
    resetN = 1'b0;
    sm     = 1'b0;
    obj    = '0;
    sof    = 1'b0;
    pause  = 1'b0;
    rl     = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    resetN = 1'b1;
  endtask

  int pc;

  initial begin
    do_reset();
    chk("reset_pulses", 32'(pulses), 32'h0);
    chk("reset_any", 32'(c_any), 32'h0);
    chk("reset_mask", 32'(mask), 32'h0);

    // Flipper overlap on non-contiguous cycles 10,11,40,41
    tick(1'b0, 5'b00000, 1'b1);
    repeat (9) tick(1'b0, 5'b00000, 1'b0);
    tick(1'b1, 5'b01000, 1'b0);
    tick(1'b1, 5'b01000, 1'b0);
    chk("t1_after2", 32'(pulses), 32'h0);
    repeat (28) tick(1'b0, 5'b00000, 1'b0);
    tick(1'b1, 5'b01000, 1'b0);
    chk("t1_after3", 32'(pulses), 32'h0);
    tick(1'b1, 5'b01000, 1'b0);
    chk("t1_pulse", 32'(pulses), 32'h08);
    chk("t1_any", 32'(c_any), 32'h1);
    tick(1'b1, 5'b01000, 1'b0);
    chk("t1_single", 32'(pulses), 32'h0);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t1_mask", 32'(mask), 32'h08);

    // Three pixels, frame boundary, one pixel: no pulse
    do_reset();
    tick(1'b0, 5'b00000, 1'b1);
    repeat (3) tick(1'b1, 5'b00001, 1'b0);
    chk("t2_three", 32'(pulses), 32'h0);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t2_mask", 32'(mask), 32'h0);
    tick(1'b1, 5'b00001, 1'b0);
    chk("t2_fourth", 32'(pulses), 32'h0);

    // Obstacle 10 px every frame with 2-frame cooldown
    do_reset();
    for (int f = 0; f < 7; f++) begin
      tick(1'b0, 5'b00000, 1'b1);
      chk($sformatf("t3_mask_f%0d", f), 32'(mask[4]), ((f > 0) && ((f - 1) % 3 == 0)) ? 32'h1 : 32'h0);
      pc = 0;
      for (int k = 0; k < 10; k++) begin
        tick(1'b1, 5'b10000, 1'b0);
        pc += int'(c_obst);
      end
      chk($sformatf("t3_pulses_f%0d", f), 32'(pc), (f % 3 == 0) ? 32'h1 : 32'h0);
    end
    tick(1'b0, 5'b00000, 1'b1);
    chk("t3_mask_last", 32'(mask[4]), 32'h1);

    // TOP and LEFT reach threshold together
    do_reset();
    tick(1'b0, 5'b00000, 1'b1);
    repeat (4) tick(1'b1, 5'b00011, 1'b0);
    chk("t4_pulses", 32'(pulses), 32'h03);
    chk("t4_any", 32'(c_any), 32'h1);
    tick(1'b0, 5'b00000, 1'b0);
    chk("t4_any_off", 32'(c_any), 32'h0);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t4_mask", 32'(mask), 32'h03);

    // Pause freezes counts and ignores startOfFrame
    do_reset();
    tick(1'b0, 5'b00000, 1'b1);
    repeat (2) tick(1'b1, 5'b01000, 1'b0);
    pause = 1'b1;
    pc = 0;
    for (int k = 0; k < 20; k++) begin
      tick(1'b1, 5'b01000, (k == 10) ? 1'b1 : 1'b0);
      pc += int'(c_any);
    end
    chk("t5_paused", 32'(pc), 32'h0);
    pause = 1'b0;
    tick(1'b1, 5'b01000, 1'b0);
    chk("t5_resume3", 32'(pulses), 32'h0);
    tick(1'b1, 5'b01000, 1'b0);
    chk("t5_resume4", 32'(pulses), 32'h08);
    chk("t5_mask_hold", 32'(mask), 32'h0);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t5_mask", 32'(mask), 32'h08);

    // Pulse registered as pause rises is dropped, not deferred
    do_reset();
    tick(1'b0, 5'b00000, 1'b1);
    repeat (4) tick(1'b1, 5'b00100, 1'b0);
    pause = 1'b1;
    #1;
    chk("t5_drop", 32'(pulses), 32'h0);
    tick(1'b0, 5'b00000, 1'b0);
    pause = 1'b0;
    pc = 0;
    for (int k = 0; k < 6; k++) begin
      tick(1'b1, 5'b00100, 1'b0);
      pc += int'(c_any);
    end
    chk("t5_no_defer", 32'(pc), 32'h0);

    // reset_level mid-cooldown (with pause high), then async reset mid-frame
    do_reset();
    tick(1'b0, 5'b00000, 1'b1);
    repeat (4) tick(1'b1, 5'b00001, 1'b0);
    chk("t6_first", 32'(pulses), 32'h01);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t6_mask", 32'(mask), 32'h01);
    pause = 1'b1;
    rl    = 1'b1;
    tick(1'b1, 5'b00001, 1'b1);
    rl    = 1'b0;
    pause = 1'b0;
    chk("t6_rl_outs", {26'h0, c_any, mask}, 32'h0);
    repeat (3) tick(1'b1, 5'b00001, 1'b0);
    chk("t6_rl_three", 32'(pulses), 32'h0);
    tick(1'b1, 5'b00001, 1'b0);
    chk("t6_rl_refire", 32'(pulses), 32'h01);
    tick(1'b0, 5'b00000, 1'b1);
    chk("t6_mask2", 32'(mask), 32'h01);
    repeat (2) tick(1'b1, 5'b10000, 1'b0);
    resetN = 1'b0;
    #1;
    chk("t6_async_outs", {21'h0, c_any, mask, pulses}, 32'h0);
    #1;
    resetN = 1'b1;
    repeat (3) tick(1'b1, 5'b10000, 1'b0);
    chk("t6_async_three", 32'(pulses), 32'h0);
    tick(1'b1, 5'b10000, 1'b0);
    chk("t6_async_refire", 32'(pulses), 32'h10);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
